seq_onehot_decoder: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with a valid/ready command port and three output modes: hold, timed pulse and auto-scan. It generalises the fixed 3-to-8 gate-level decoder to 2^SEL_W outputs. It drives strobe/select lines for peripheral banks, LED or keypad column scanning, and chip-select fan-out where outputs must be glitch-free and time-controlled.

---
 rtl/seq_onehot_decoder_pkg.sv | 19 +
 rtl/seq_onehot_decoder_if.sv | 26 ++
 rtl/seq_onehot_decoder_onehot_dec.sv | 16 +
 rtl/seq_onehot_decoder.sv | 140 ++++++++++++++
 tb/tb_seq_onehot_decoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_onehot_decoder_pkg.sv
// Shared types for the sequenced one-hot decoder.
// Command modes and FSM state encodings.
package dec_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        PULSE,
        SCAN
    } state_t;

endpackage

// File: rtl/seq_onehot_decoder_if.sv
// Command port of the sequenced one-hot decoder.
// Valid/ready handshake carrying an output index and a mode.
interface seq_onehot_decoder_if #(
    parameter int SEL_W = 3
) ();

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [1:0]       mode;

    modport master (
        output in_valid,
        output sel,
        output mode,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  sel,
        input  mode,
        output in_ready
    );

endinterface

// File: rtl/seq_onehot_decoder_onehot_dec.sv
// Combinational binary-to-one-hot decoder.
// Exactly one output bit is set for any input index.
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]    idx,
    output logic [2**SEL_W-1:0] oh
);

    // Set the single bit addressed by idx.
    always_comb begin
        oh      = '0;
        oh[idx] = 1'b1;
    end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered one-hot decoder with hold, timed pulse and scan modes.
// One shared decoder feeds y from either the command or the scan index.
module seq_onehot_decoder
    import dec_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int PULSE_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    seq_onehot_decoder_if.slave  cmd,
    output logic [2**SEL_W-1:0]  y,
    output logic                 busy,
    output logic                 done
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CW    = $clog2(PULSE_LEN + 1);

    state_t           state_q;
    state_t           state_d;
    logic [OUT_W-1:0] y_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_d;
    logic [SEL_W-1:0] steps_q;
    logic [SEL_W-1:0] steps_d;
    logic             done_q;
    logic             done_d;
    logic             accept;
    logic [SEL_W-1:0] idx_inc;
    logic [SEL_W-1:0] dec_in;
    logic [OUT_W-1:0] dec_oh;
    mode_t            cmd_mode;

    assign cmd_mode     = mode_t'(cmd.mode);
    assign cmd.in_ready = en & (state_q == IDLE | state_q == HOLD);
    assign accept       = cmd.in_valid & cmd.in_ready;
    assign idx_inc      = idx_q + SEL_W'(1);
    assign dec_in       = accept ? cmd.sel : idx_inc;
    assign busy         = (state_q == PULSE) | (state_q == SCAN);
    assign done         = done_q & en;

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .idx (dec_in),
        .oh  (dec_oh)
    );

    // State, output and counter registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y       <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            steps_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y       <= y_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            steps_q <= steps_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; with en low everything holds.
    always_comb begin
        state_d = state_q;
        y_d     = y;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        steps_d = steps_q;
        done_d  = done_q;
        if (en) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        unique case (cmd_mode)
                            MODE_HOLD: begin
                                y_d     = dec_oh;
                                state_d = HOLD;
                            end
                            MODE_PULSE: begin
                                y_d     = dec_oh;
                                cnt_d   = CW'(PULSE_LEN - 1);
                                state_d = PULSE;
                            end
                            MODE_SCAN: begin
                                y_d     = dec_oh;
                                idx_d   = cmd.sel;
                                steps_d = SEL_W'(OUT_W - 1);
                                state_d = SCAN;
                            end
                            MODE_CLEAR: begin
                                y_d     = '0;
                                state_d = IDLE;
                            end
                            default: begin
                                y_d     = '0;
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        y_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                SCAN: begin
                    if (steps_q == '0) begin
                        y_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_inc;
                        y_d     = dec_oh;
                        steps_d = steps_q - SEL_W'(1);
                    end
                end
                default: begin
                    y_d     = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Self-checking bench for seq_onehot_decoder.
// Reference model tracks the list of upcoming outputs per operation.
module tb_seq_onehot_decoder;

    localparam int SEL_W     = 3;
    localparam int OUT_W     = 8;
    localparam int PULSE_LEN = 4;

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_PULSE = 2'b01;
    localparam logic [1:0] M_SCAN  = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [OUT_W-1:0] y;
    logic             busy;
    logic             done;

    seq_onehot_decoder_if #(.SEL_W(SEL_W)) cmd ();

    seq_onehot_decoder #(
        .SEL_W     (SEL_W),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .cmd   (cmd),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_y;
    int q[$];
    bit m_active;
    bit m_done;
    bit last_acc;

    function automatic int oh(int i);
        return 1 << i;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_y = 0;
        q.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
    endtask

    task automatic check_all(string ctx);
        chk({ctx, ":y"}, 32'(y), m_y);
        chk({ctx, ":busy"}, 32'(busy), 32'(m_active));
        chk({ctx, ":done"}, 32'(done), 32'(m_done && en));
        chk({ctx, ":in_ready"}, 32'(cmd.in_ready),
            32'(en && !m_active));
        chk({ctx, ":onehot"}, 32'($countones(y) <= 1), 1);
    endtask

    task automatic step();
        bit acc;
        int s;
        int md;
        acc = cmd.in_valid && en && !m_active && rst_n;
        md  = int'(cmd.mode);
        s   = int'(cmd.sel);
        @(posedge clk);
        last_acc = acc;
        if (en && rst_n) begin
            m_done = 1'b0;
            if (acc) begin
                q.delete();
                case (md)
                    0: m_y = oh(s);
                    1: begin
                        m_y = oh(s);
                        for (int k = 1; k < PULSE_LEN; k++)
                            q.push_back(oh(s));
                        m_active = 1'b1;
                    end
                    2: begin
                        m_y = oh(s);
                        for (int k = 1; k < OUT_W; k++)
                            q.push_back(oh((s + k) % OUT_W));
                        m_active = 1'b1;
                    end
                    default: m_y = 0;
                endcase
            end else if (m_active) begin
                if (q.size() > 0) begin
                    m_y = q.pop_front();
                end else begin
                    m_y      = 0;
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
        #1;
        check_all("step");
    endtask

    task automatic send(logic [1:0] m, int s);
        cmd.mode     = m;
        cmd.sel      = s[SEL_W-1:0];
        cmd.in_valid = 1'b1;
        last_acc     = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (last_acc) break;
        end
        chk("send_accept", 32'(last_acc), 1);
        cmd.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] scan_exp [9];
        int n;
        scan_exp = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04,
                     8'h08, 8'h10, 8'h20, 8'h00};

        rst_n        = 1'b0;
        en           = 1'b0;
        cmd.in_valid = 1'b1;
        cmd.mode     = M_HOLD;
        cmd.sel      = 3'd5;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_en0");
        en = 1'b1;
        #1;
        check_all("reset_en1");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        cmd.in_valid = 1'b0;
        rst_n        = 1'b1;
        step();

        send(M_HOLD, 5);
        chk("hold5", 32'(y), 32'h20);
        send(M_HOLD, 2);
        chk("hold2", 32'(y), 32'h04);
        step();

        send(M_PULSE, 7);
        chk("pulse7", 32'(y), 32'h80);
        send(M_HOLD, 1);
        chk("held_cmd", 32'(y), 32'h02);
        send(M_CLEAR, 0);
        chk("clear", 32'(y), 0);
        send(M_CLEAR, 0);
        step();

        send(M_SCAN, 6);
        chk("scan0", 32'(y), 32'(scan_exp[0]));
        for (int k = 1; k < 9; k++) begin
            step();
            chk("scan_seq", 32'(y), 32'(scan_exp[k]));
        end
        chk("scan_done", 32'(done), 1);
        step();

        send(M_PULSE, 3);
        n = (y == 8'h08) ? 1 : 0;
        step();
        n += (y == 8'h08) ? 1 : 0;
        en = 1'b0;
        repeat (2) begin
            step();
            n += (y == 8'h08) ? 1 : 0;
        end
        en = 1'b1;
        repeat (6) begin
            step();
            n += (y == 8'h08) ? 1 : 0;
        end
        chk("pulse_en_len", n, 6);

        send(M_SCAN, 0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst_n = 1'b1;
        step();
        send(M_HOLD, 1);
        chk("after_rst", 32'(y), 32'h02);

        for (int i = 0; i < 400; i++) begin
            en           = ($urandom_range(0, 9) != 0);
            cmd.in_valid = 1'($urandom_range(0, 1));
            cmd.mode     = 2'($urandom_range(0, 3));
            cmd.sel      = 3'($urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
